// File: rtl/simplez_sequencer.sv
// simplez_sequencer: hardwired I0/I1/O0/O1/HLT control unit for the Simplez datapath.
// Define SIMPLEZ_SEQ_WAIT_EN to add a mem_rdy handshake that stretches the I0 and O0 memory states.
module simplez_sequencer #(
    parameter int CNTW = 16,
    parameter int OPW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    input  logic            start,
`ifdef SIMPLEZ_SEQ_WAIT_EN
    input  logic            mem_rdy,
`endif
    output logic            lec,
    output logic            esc,
    output logic            era,
    output logic            incp,
    output logic            ecp,
    output logic            scp,
    output logic            eri,
    output logic            sri,
    output logic            eac,
    output logic            sac,
    output logic [1:0]      alu_op,
    output logic            stop,
    output logic [2:0]      state,
    output logic [CNTW-1:0] inst_count
);
    localparam logic [2:0] I0 = 3'd0, I1 = 3'd1, O0 = 3'd2, O1 = 3'd3, HLT = 3'd4;
    localparam logic [OPW-1:0] OP_ST = OPW'(0), OP_LD = OPW'(1), OP_ADD = OPW'(2), OP_BR = OPW'(3),
                               OP_BZ = OPW'(4), OP_CLR = OPW'(5), OP_DEC = OPW'(6), OP_HALT = OPW'(7);
    logic [2:0] nxt;
    logic       rdy;
    logic       retire;
`ifdef SIMPLEZ_SEQ_WAIT_EN
    assign rdy = mem_rdy;
`else
    assign rdy = 1'b1;
`endif
    // HALT retires on entry to HLT; every other instruction retires on its return to I0
    assign retire = (state == I1 && nxt != O0) || state == O1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= I0;
            inst_count <= '0;
        end else begin
            state      <= nxt;
            inst_count <= inst_count + CNTW'(retire);
        end
    end
    always_comb begin
        nxt = I0;
        case (state)
            I0:      nxt = rdy ? I1 : I0;
            I1:      nxt = opcode == OP_HALT ? HLT :
                           (opcode == OP_ST || opcode == OP_LD || opcode == OP_ADD) ? O0 : I0;
            O0:      nxt = rdy ? O1 : O0;
            O1:      nxt = I0;
            HLT:     nxt = start ? O1 : HLT;
            default: nxt = I0;
        endcase
    end
    always_comb begin
        lec    = 1'b0;
        esc    = 1'b0;
        era    = 1'b0;
        incp   = 1'b0;
        ecp    = 1'b0;
        scp    = 1'b0;
        eri    = 1'b0;
        sri    = 1'b0;
        eac    = 1'b0;
        sac    = 1'b0;
        alu_op = 2'b00;
        stop   = 1'b0;
        case (state)
            I0: begin
                lec  = 1'b1;
                eri  = rdy;
                incp = rdy;
            end
            I1: begin
                case (opcode)
                    OP_ST, OP_LD, OP_ADD: begin
                        sri = 1'b1;
                        era = 1'b1;
                    end
                    OP_BR: begin
                        sri = 1'b1;
                        era = 1'b1;
                        ecp = 1'b1;
                    end
                    OP_BZ: begin
                        sri = zero;
                        ecp = zero;
                        scp = !zero;
                        era = 1'b1;
                    end
                    OP_CLR, OP_DEC: begin
                        eac    = 1'b1;
                        alu_op = opcode == OP_CLR ? 2'b11 : 2'b10;
                        scp    = 1'b1;
                        era    = 1'b1;
                    end
                    default: ;
                endcase
            end
            O0: begin
                sac    = opcode == OP_ST;
                esc    = opcode == OP_ST && rdy;
                lec    = opcode == OP_LD || opcode == OP_ADD;
                eac    = (opcode == OP_LD || opcode == OP_ADD) && rdy;
                alu_op = opcode == OP_ADD ? 2'b01 : 2'b00;
            end
            O1: begin
                scp = 1'b1;
                era = 1'b1;
            end
            HLT:     stop = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_simplez_sequencer.sv
// tb_simplez_sequencer: directed vectors for the Simplez sequencer, with a 4-bit-counter
// twin instance that exercises counter wrap within a short run.
module tb_simplez_sequencer;
    logic clk = 1'b0, rst = 1'b1, zero = 1'b0, start = 1'b0;
    logic [2:0] opcode = 3'd0;
`ifdef SIMPLEZ_SEQ_WAIT_EN
    logic mem_rdy = 1'b1;
`endif
    logic lec, esc, era, incp, ecp, scp, eri, sri, eac, sac, stop;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic [15:0] inst_count;
    logic s_lec, s_esc, s_era, s_incp, s_ecp, s_scp, s_eri, s_sri, s_eac, s_sac, s_stop;
    logic [1:0] s_alu_op;
    logic [2:0] s_state;
    logic [3:0] s_inst_count;
    logic [12:0] mo, mo_s;
    int tests = 0, fails = 0;
    localparam logic [12:0] LEC = 13'h1000, ESC = 13'h0800, ERA = 13'h0400, INCP = 13'h0200,
                            ECP = 13'h0100, SCP = 13'h0080, ERI = 13'h0040, SRI = 13'h0020,
                            EAC = 13'h0010, SAC = 13'h0008, A01 = 13'h0002, A10 = 13'h0004,
                            A11 = 13'h0006, STOP = 13'h0001;
    localparam logic [12:0] M_I0 = LEC | ERI | INCP;
    assign mo   = {lec, esc, era, incp, ecp, scp, eri, sri, eac, sac, alu_op, stop};
    assign mo_s = {s_lec, s_esc, s_era, s_incp, s_ecp, s_scp, s_eri, s_sri, s_eac, s_sac, s_alu_op, s_stop};
    always #5 clk = ~clk;

    simplez_sequencer #(.CNTW(16), .OPW(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .start(start),
`ifdef SIMPLEZ_SEQ_WAIT_EN
        .mem_rdy(mem_rdy),
`endif
        .lec(lec), .esc(esc), .era(era), .incp(incp), .ecp(ecp), .scp(scp), .eri(eri),
        .sri(sri), .eac(eac), .sac(sac), .alu_op(alu_op), .stop(stop), .state(state),
        .inst_count(inst_count)
    );
    simplez_sequencer #(.CNTW(4), .OPW(3)) dut_s (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .start(start),
`ifdef SIMPLEZ_SEQ_WAIT_EN
        .mem_rdy(mem_rdy),
`endif
        .lec(s_lec), .esc(s_esc), .era(s_era), .incp(s_incp), .ecp(s_ecp), .scp(s_scp),
        .eri(s_eri), .sri(s_sri), .eac(s_eac), .sac(s_sac), .alu_op(s_alu_op), .stop(s_stop),
        .state(s_state), .inst_count(s_inst_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // one clock: outputs are sampled just after the falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_cyc(input string tag, input logic [2:0] st, input logic [12:0] m);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".mo"}, 32'(mo), 32'(m));
    endtask

    initial begin
        step();
        rst = 1'b0;
        chk_cyc("reset", 3'd0, M_I0);
        chk("reset.cnt", 32'(inst_count), 32'd0);
        opcode = 3'd2;
        step(); chk_cyc("add.i1", 3'd1, SRI | ERA);
        step(); chk_cyc("add.o0", 3'd2, LEC | EAC | A01);
        step(); chk_cyc("add.o1", 3'd3, SCP | ERA);
        chk("add.cnt_o1", 32'(inst_count), 32'd0);
        step(); chk_cyc("add.i0", 3'd0, M_I0);
        chk("add.cnt", 32'(inst_count), 32'd1);
        opcode = 3'd4; zero = 1'b1;
        step(); chk_cyc("bz1.i1", 3'd1, SRI | ERA | ECP);
        step(); chk_cyc("bz1.i0", 3'd0, M_I0);
        zero = 1'b0;
        step(); chk_cyc("bz0.i1", 3'd1, SCP | ERA);
        step(); chk_cyc("bz0.i0", 3'd0, M_I0);
        chk("bz.cnt", 32'(inst_count), 32'd3);
        opcode = 3'd0;
        step(); chk_cyc("st.i1", 3'd1, SRI | ERA);
        step(); chk_cyc("st.o0", 3'd2, SAC | ESC);
        step(); step(); chk("st.cnt", 32'(inst_count), 32'd4);
        opcode = 3'd1;
        step(); step(); chk_cyc("ld.o0", 3'd2, LEC | EAC);
        step(); step(); chk("ld.cnt", 32'(inst_count), 32'd5);
        opcode = 3'd5;
        step(); chk_cyc("clr.i1", 3'd1, EAC | A11 | SCP | ERA);
        step(); chk_cyc("clr.i0", 3'd0, M_I0);
        opcode = 3'd6;
        step(); chk_cyc("dec.i1", 3'd1, EAC | A10 | SCP | ERA);
        step();
        opcode = 3'd3;
        step(); chk_cyc("br.i1", 3'd1, SRI | ERA | ECP);
        step(); chk("br.cnt", 32'(inst_count), 32'd8);
        start = 1'b1;
        step(); chk_cyc("start_in_i0", 3'd1, SRI | ERA | ECP);
        start = 1'b0;
        step();
        opcode = 3'd7;
        step(); chk_cyc("halt.i1", 3'd1, 13'h0);
        step(); chk("halt.cnt", 32'(inst_count), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk_cyc("halt.hold", 3'd4, STOP);
            step();
        end
        chk("halt.cnt_hold", 32'(inst_count), 32'd10);
        start = 1'b1;
        step(); chk_cyc("restart.o1", 3'd3, SCP | ERA);
        start = 1'b0;
        step(); chk_cyc("restart.i0", 3'd0, M_I0);
        chk("restart.cnt", 32'(inst_count), 32'd11);
        opcode = 3'd2;
        step(); step(); chk_cyc("rst_mid.o0", 3'd2, LEC | EAC | A01);
        rst = 1'b1;
        #1;
        chk_cyc("rst_mid", 3'd0, M_I0);
        chk("rst_mid.cnt", 32'(inst_count), 32'd0);
        step();
        rst = 1'b0;
        opcode = 3'd6;
        for (int i = 0; i < 15; i++) begin
            step(); step();
        end
        chk("wrap.cnt15", 32'(s_inst_count), 32'd15);
        step(); step();
        chk("wrap.cnt0", 32'(s_inst_count), 32'd0);
        chk("wrap.cnt16", 32'(inst_count), 32'd16);
        chk("wrap.mo", 32'(mo_s), 32'(M_I0));
`ifdef SIMPLEZ_SEQ_WAIT_EN
        mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_cyc("wait.i0", 3'd0, LEC);
            step();
        end
        mem_rdy = 1'b1;
        chk_cyc("wait.i0_rdy", 3'd0, M_I0);
        opcode = 3'd1;
        step(); chk_cyc("wait.i1", 3'd1, SRI | ERA);
        mem_rdy = 1'b0;
        step(); chk_cyc("wait.o0", 3'd2, LEC);
        step(); chk_cyc("wait.o0_hold", 3'd2, LEC);
        mem_rdy = 1'b1;
        chk_cyc("wait.o0_rdy", 3'd2, LEC | EAC);
        step(); chk_cyc("wait.o1", 3'd3, SCP | ERA);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
